// File: rtl/mem_stage_responder.sv
// Data-memory responder for the control unit's MEM stage.
// Serves word/byte loads and stores on an internal word-organised RAM with a
// fixed number of wait states, then pulses memReady for one cycle.
// Ports:
//   clock, reset_n                     clock and async active-low reset
//   enMem                              MEM-stage enable (rising edge starts a request)
//   sigMemR, sigMemW                   read / write request (exactly one must be set)
//   sigByte, sigExt                    byte access select, byte-load sign extension
//   address, dataIn                    byte address, store data
//   dataOut                            load result (held until the next completed read)
//   memReady, memBusy, memError        completion pulse, in-progress flag, reject pulse
module mem_stage_responder #(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  enMem,
   input  logic                  sigMemR,
   input  logic                  sigMemW,
   input  logic                  sigByte,
   input  logic                  sigExt,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] dataIn,
   output logic [DATA_WIDTH-1:0] dataOut,
   output logic                  memReady,
   output logic                  memBusy,
   output logic                  memError
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    en_q;

   // Request captured at acceptance
   logic [IDX_W-1:0]        idx_q;
   logic                    lo_q, byte_q, ext_q, wr_q;
   logic [DATA_WIDTH-1:0]   din_q;

   logic [DATA_WIDTH-1:0]   ram [DEPTH];

   logic                    rise, capture, error_d, ready_d, busy_d, we;
   logic                    misaligned, in_range;
   logic [ADDR_WIDTH-2:0]   word_idx;
   logic [IDX_W-1:0]        acc_idx;
   logic                    acc_lo, acc_byte, acc_ext, acc_wr;
   logic [DATA_WIDTH-1:0]   acc_din, rd_word, wdata, dout_d;
   logic [7:0]              sel_byte;

   assign rise       = enMem & ~en_q;
   assign word_idx   = address[ADDR_WIDTH-1:1];
   assign misaligned = ~sigByte & address[0];
   assign in_range   = {1'b0, word_idx} < ADDR_WIDTH'(DEPTH);

   // Next-state, acceptance checks and registered-output next values
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      capture  = 1'b0;
      error_d  = 1'b0;
      ready_d  = 1'b0;
      busy_d   = 1'b0;
      we       = 1'b0;
      dout_d   = dataOut;
      wdata    = '0;
      sel_byte = '0;

      case (state_q)
         IDLE: begin
            if (rise) begin
               if (sigMemR & sigMemW) begin
                  error_d = 1'b1;
               end else if (sigMemR ^ sigMemW) begin
                  if (misaligned | ~in_range) begin
                     error_d = 1'b1;
                  end else begin
                     capture = 1'b1;
                     if (WAIT_CYCLES == 0) begin
                        state_d = RESPOND;
                     end else begin
                        state_d = ACCESS;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                     end
                  end
               end
            end
         end
         ACCESS: begin
            if (cnt_q == '0) state_d = RESPOND;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         RESPOND: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // With zero wait states the access happens on the accepting edge itself,
      // so the live inputs are used while still in IDLE.
      if (state_q == IDLE) begin
         acc_idx  = word_idx[IDX_W-1:0];
         acc_lo   = address[0];
         acc_byte = sigByte;
         acc_ext  = sigExt;
         acc_wr   = sigMemW;
         acc_din  = dataIn;
      end else begin
         acc_idx  = idx_q;
         acc_lo   = lo_q;
         acc_byte = byte_q;
         acc_ext  = ext_q;
         acc_wr   = wr_q;
         acc_din  = din_q;
      end

      rd_word = ram[acc_idx];

      if (state_d == RESPOND) begin
         ready_d = 1'b1;
         if (acc_wr) begin
            we = 1'b1;
            if (!acc_byte)   wdata = acc_din;
            else if (acc_lo) wdata = {acc_din[7:0], rd_word[7:0]};
            else             wdata = {rd_word[15:8], acc_din[7:0]};
         end else begin
            sel_byte = acc_lo ? rd_word[15:8] : rd_word[7:0];
            if (acc_byte) dout_d = {{8{acc_ext & sel_byte[7]}}, sel_byte};
            else          dout_d = rd_word;
         end
      end

      busy_d = (state_d != IDLE);
   end

   // State register, request capture and registered outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         en_q     <= 1'b0;
         idx_q    <= '0;
         lo_q     <= 1'b0;
         byte_q   <= 1'b0;
         ext_q    <= 1'b0;
         wr_q     <= 1'b0;
         din_q    <= '0;
         dataOut  <= '0;
         memReady <= 1'b0;
         memBusy  <= 1'b0;
         memError <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         en_q     <= enMem;
         dataOut  <= dout_d;
         memReady <= ready_d;
         memBusy  <= busy_d;
         memError <= error_d;
         if (capture) begin
            idx_q  <= word_idx[IDX_W-1:0];
            lo_q   <= address[0];
            byte_q <= sigByte;
            ext_q  <= sigExt;
            wr_q   <= sigMemW;
            din_q  <= dataIn;
         end
      end
   end

   // RAM contents survive reset; writes are blocked while reset is held
   always_ff @(posedge clock) begin
      if (we && reset_n) ram[acc_idx] <= wdata;
   end

endmodule

// File: tb/tb_mem_stage_responder.sv
// Self-checking bench for mem_stage_responder: a WAIT_CYCLES=2 instance (d=0)
// and a WAIT_CYCLES=0 instance (d=1), checked against a word-array model.
module tb_mem_stage_responder;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic [1:0]  en, rd, wr, bt, ext;
   logic [15:0] addr_v [2];
   logic [15:0] din_v  [2];
   logic [15:0] dout_v [2];
   logic [1:0]  ready, busy, err;

   int tests = 0;
   int fails = 0;

   logic [15:0] model  [2][256];
   logic [15:0] dout_m [2];

   always #5 clock = ~clock;

   mem_stage_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(256), .WAIT_CYCLES(2)) dut (
      .clock(clock), .reset_n(reset_n), .enMem(en[0]), .sigMemR(rd[0]), .sigMemW(wr[0]),
      .sigByte(bt[0]), .sigExt(ext[0]), .address(addr_v[0]), .dataIn(din_v[0]),
      .dataOut(dout_v[0]), .memReady(ready[0]), .memBusy(busy[0]), .memError(err[0]));

   mem_stage_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
      .clock(clock), .reset_n(reset_n), .enMem(en[1]), .sigMemR(rd[1]), .sigMemW(wr[1]),
      .sigByte(bt[1]), .sigExt(ext[1]), .address(addr_v[1]), .dataIn(din_v[1]),
      .dataOut(dout_v[1]), .memReady(ready[1]), .memBusy(busy[1]), .memError(err[1]));

   function automatic logic [15:0] model_read(input int d, input int a, input bit b, input bit x);
      int w, v;
      w = int'(model[d][(a / 2) % 256]);
      if (!b) return 16'(w);
      v = (a % 2 == 1) ? (w / 256) % 256 : w % 256;
      if (x && v >= 128) v = v + 'hFF00;
      return 16'(v);
   endfunction

   function automatic logic [15:0] model_merge(input int d, input int a, input bit b, input int data);
      int w;
      w = int'(model[d][(a / 2) % 256]);
      if (!b) return 16'(data);
      if (a % 2 == 1) return 16'((w % 256) + (data % 256) * 256);
      return 16'((w / 256) * 256 + (data % 256));
   endfunction

   // One MEM-stage request; kind 0 = accepted, 1 = rejected, 2 = ignored
   task automatic run_op(input int d, input bit r, input bit w, input bit b, input bit x,
                         input logic [15:0] a, input logic [15:0] dat, input string name);
      int wc, kind;
      logic [15:0] exp_rd;
      logic [2:0]  obs, expv;
      wc = (d == 0) ? 2 : 0;
      if (r && w)                                   kind = 1;
      else if (!r && !w)                            kind = 2;
      else if ((!b && a[0]) || (int'(a) / 2) >= 256) kind = 1;
      else                                          kind = 0;
      exp_rd = (kind == 0 && r) ? model_read(d, int'(a), b, x) : 16'h0;

      @(posedge clock); #1;
      rd[d] = r; wr[d] = w; bt[d] = b; ext[d] = x; addr_v[d] = a; din_v[d] = dat; en[d] = 1'b1;
      for (int k = 1; k <= wc + 2; k++) begin
         @(posedge clock); #1;
         if (k == 1) begin
            addr_v[d] = 16'($urandom); din_v[d] = 16'($urandom);
            bt[d] = 1'($urandom_range(0, 1)); ext[d] = 1'($urandom_range(0, 1));
            rd[d] = 1'($urandom_range(0, 1)); wr[d] = 1'($urandom_range(0, 1));
         end
         obs = {ready[d], busy[d], err[d]};
         case (kind)
            0:       expv = {k == wc + 1, k <= wc + 1, 1'b0};
            1:       expv = {2'b00, k == 1};
            default: expv = 3'b000;
         endcase
         tests++;
         if (obs !== expv) begin
            fails++;
            $display("FAIL %s flags(rdy,bsy,err) k=%0d got %b want %b", name, k, obs, expv);
         end
         if (kind == 0 && r && k == wc + 1) begin
            dout_m[d] = exp_rd;
            tests++;
            if (dout_v[d] !== exp_rd) begin
               fails++;
               $display("FAIL %s read data got %h want %h", name, dout_v[d], exp_rd);
            end
         end
      end
      if (kind == 0 && w) model[d][(int'(a) / 2) % 256] = model_merge(d, int'(a), b, int'(dat));
      if (kind != 0 || w) begin
         tests++;
         if (dout_v[d] !== dout_m[d]) begin
            fails++;
            $display("FAIL %s dataOut held got %h want %h", name, dout_v[d], dout_m[d]);
         end
      end
      en[d] = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({ready[d], busy[d], err[d], dout_v[d]} !== 19'h0) begin
            fails++;
            $display("FAIL reset_values d=%0d got %b_%h want 000_0000", d,
                     {ready[d], busy[d], err[d]}, dout_v[d]);
         end
         dout_m[d] = 16'h0;
      end
      reset_n = 1'b1;
   endtask

   task automatic test_word();
      run_op(0, 0, 1, 0, 0, 16'h0010, 16'hBEEF, "word_write");
      run_op(0, 1, 0, 0, 0, 16'h0010, 16'h0000, "word_read");
   endtask

   task automatic test_byte_lanes();
      run_op(0, 0, 1, 0, 0, 16'h0020, 16'h0000, "bl_clear");
      run_op(0, 0, 1, 1, 0, 16'h0021, 16'h1285, "bl_store_hi");
      run_op(0, 1, 0, 0, 0, 16'h0020, 16'h0000, "bl_word");
      run_op(0, 1, 0, 1, 1, 16'h0021, 16'h0000, "bl_sext");
      run_op(0, 1, 0, 1, 0, 16'h0021, 16'h0000, "bl_zext");
      run_op(0, 1, 0, 1, 1, 16'h0020, 16'h0000, "bl_low");
   endtask

   task automatic test_errors();
      run_op(0, 1, 0, 0, 0, 16'h0011, 16'h0000, "err_misaligned");
      run_op(0, 1, 0, 0, 0, 16'h0200, 16'h0000, "err_range");
      run_op(0, 1, 1, 0, 0, 16'h0010, 16'h1111, "err_both");
      run_op(0, 1, 0, 0, 0, 16'h0010, 16'h0000, "err_ram_kept");
      run_op(0, 0, 0, 0, 0, 16'h0010, 16'h2222, "none_ignored");
   endtask

   task automatic test_held_high();
      int cnt;
      logic [15:0] exp_rd;
      exp_rd = model_read(0, 'h10, 1'b0, 1'b0);
      cnt = 0;
      @(posedge clock); #1;
      rd[0] = 1; wr[0] = 0; bt[0] = 0; ext[0] = 0; addr_v[0] = 16'h0010; en[0] = 1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clock); #1;
         if (ready[0]) cnt++;
      end
      dout_m[0] = exp_rd;
      tests++;
      if (cnt !== 1) begin
         fails++;
         $display("FAIL held_high ready pulses got %0d want 1", cnt);
      end
      tests++;
      if (dout_v[0] !== exp_rd) begin
         fails++;
         $display("FAIL held_high data got %h want %h", dout_v[0], exp_rd);
      end
      en[0] = 0;
   endtask

   task automatic test_second_pulse();
      int cnt;
      logic [15:0] exp_rd;
      exp_rd = model_read(0, 'h20, 1'b0, 1'b0);
      cnt = 0;
      @(posedge clock); #1;
      rd[0] = 1; wr[0] = 0; bt[0] = 0; ext[0] = 0; addr_v[0] = 16'h0020; en[0] = 1;
      @(posedge clock); #1;
      en[0] = 0;
      @(posedge clock); #1;
      en[0] = 1; addr_v[0] = 16'h0010;
      for (int k = 0; k < 8; k++) begin
         @(posedge clock); #1;
         if (ready[0]) cnt++;
      end
      dout_m[0] = exp_rd;
      tests++;
      if (cnt !== 1 || busy[0] !== 1'b0) begin
         fails++;
         $display("FAIL second_pulse pulses/busy got %0d/%b want 1/0", cnt, busy[0]);
      end
      tests++;
      if (dout_v[0] !== exp_rd) begin
         fails++;
         $display("FAIL second_pulse data got %h want %h", dout_v[0], exp_rd);
      end
      en[0] = 0;
   endtask

   task automatic test_reset_mid_write();
      run_op(0, 0, 1, 0, 0, 16'h0030, 16'h5555, "rst_prefill");
      @(posedge clock); #1;
      rd[0] = 0; wr[0] = 1; bt[0] = 0; addr_v[0] = 16'h0030; din_v[0] = 16'h1234; en[0] = 1;
      @(posedge clock); #1;
      #2 reset_n = 1'b0;
      #1;
      tests++;
      if ({ready[0], busy[0], err[0], dout_v[0]} !== 19'h0) begin
         fails++;
         $display("FAIL reset_mid_write outputs got %b_%h want 000_0000",
                  {ready[0], busy[0], err[0]}, dout_v[0]);
      end
      dout_m[0] = 16'h0; dout_m[1] = 16'h0;
      en[0] = 0;
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      run_op(0, 1, 0, 0, 0, 16'h0030, 16'h0000, "rst_read_old");
   endtask

   task automatic test_zero_wait();
      run_op(1, 0, 1, 0, 0, 16'h0010, 16'hA5A5, "zw_write");
      run_op(1, 1, 0, 0, 0, 16'h0010, 16'h0000, "zw_read");
      run_op(1, 1, 0, 1, 1, 16'h0011, 16'h0000, "zw_byte_sext");
      run_op(1, 1, 0, 0, 0, 16'h0013, 16'h0000, "zw_misaligned");
   endtask

   task automatic test_random();
      int d, sel;
      bit r, w;
      logic [15:0] a;
      for (int dd = 0; dd < 2; dd++)
         for (int i = 0; i < 32; i++)
            run_op(dd, 0, 1, 0, 0, 16'(2 * i), 16'($urandom), "rnd_init");
      for (int i = 0; i < 150; i++) begin
         d   = $urandom_range(0, 1);
         sel = $urandom_range(0, 15);
         if (sel == 0)      begin r = 1; w = 1; end
         else if (sel == 1) begin r = 0; w = 0; end
         else begin r = 1'($urandom_range(0, 1)); w = !r; end
         a = 16'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(512, 65535));
         run_op(d, r, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                16'($urandom), "rnd_op");
      end
   endtask

   initial begin
      en = '0; rd = '0; wr = '0; bt = '0; ext = '0;
      addr_v[0] = '0; addr_v[1] = '0; din_v[0] = '0; din_v[1] = '0;
      #2;
      test_reset();
      test_word();
      test_byte_lanes();
      test_errors();
      test_held_high();
      test_second_pulse();
      test_reset_mid_write();
      test_zero_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
